alu_share_ctrl: RTL

Two-requester round-robin controller that time-shares the single combinational ALU between the integer pipe (port 0) and the address/branch helper (port 1). It latches the winning request's opcode and operands, drives the shared ALU for one cycle, and registers the result. It then returns the result with a one-cycle response pulse to the granted requester. It sits between the requesters and the ALU instance, with ALU inputs driven only from its registers.

---
 rtl/alu_share_ctrl_pkg.sv | 29 ++
 rtl/alu_share_ctrl_arb.sv | 21 ++
 rtl/alu_share_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU opcode constants, controller state encoding
// and the legal-opcode test used by the ALU decoder and alu_share_ctrl.
package alu_share_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// rr_arb2: combinational 2-way round-robin pick.
// Ports: req[1:0] requests, last_grant -> valid (any req), id (winner).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = 1'b0;
    case (req)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ~last_grant;
      default: id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters.
// Ports: req0/1 ctl/a/b in, gnt/rsp_valid/rsp_* out, alu_* to/from ALU.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_i,
  input  logic [3:0]       req0_ctl_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_i,
  input  logic [3:0]       req1_ctl_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o,
  output logic [3:0]       alu_ctl_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_out_i
);

  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             pick_valid;
  logic             pick_id;
  logic             legal;

  rr_arb2 u_arb (
    .req        ({req1_i, req0_i}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  assign legal = is_legal_op(ctl_q);

  assign alu_ctl_o = ctl_q;
  assign alu_a_o   = a_q;
  assign alu_b_o   = b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      id_q         <= 1'b0;
      ctl_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      gnt0_o       <= 1'b0;
      gnt1_o       <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp_data_o   <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_ISSUE;
            id_q       <= pick_id;
            last_grant <= pick_id;
            ctl_q      <= pick_id ? req1_ctl_i : req0_ctl_i;
            a_q        <= pick_id ? req1_a_i : req0_a_i;
            b_q        <= pick_id ? req1_b_i : req0_b_i;
            gnt0_o     <= ~pick_id;
            gnt1_o     <= pick_id;
          end
        end
        ST_ISSUE: begin
          state        <= ST_DONE;
          // Illegal opcodes report err and a clean zero result.
          rsp_data_o   <= legal ? alu_out_i : '0;
          rsp_zero_o   <= (ctl_q == OP_SUB) && (alu_out_i == '0);
          rsp_err_o    <= ~legal;
          rsp0_valid_o <= ~id_q;
          rsp1_valid_o <= id_q;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          gnt0_o <= 1'b0;
          gnt1_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
